// File: rtl/bcd_convert_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

   localparam int unsigned BCD_DIGIT_W = 4;

   typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONV,
      ST_DONE
   } state_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_convert_seq_add3.sv
// Combinational double-dabble correction: a BCD digit of 5 or more gets +3.
module bcd_add3_cell
   import bcd_pkg::*;
(
   input  bcd_digit_t digit_i,
   output bcd_digit_t digit_o
);

   always_comb begin
      digit_o = digit_i;
      if (digit_i >= bcd_digit_t'(5)) digit_o = digit_i + bcd_digit_t'(3);
   end

endmodule

// File: rtl/bcd_convert_seq.sv
// Iterative (shift-add-3) binary-to-BCD converter with valid/ready handshakes.
// Optional leading-zero blank mask on out_blank when BCD_BLANK_EN is defined.
module bcd_convert_seq
   import bcd_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DIGITS = 5
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_W-1:0]             in_data,
   input  logic                          in_signed,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BCD_DIGIT_W*DIGITS-1:0] out_digits,
   output logic                          out_sign,
   output logic                          out_overflow,
   output logic [DIGITS-1:0]             out_blank
);

   localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int unsigned CNT_W = clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  mag_q, mag_d, mag_shift;
   logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj, bcd_shift;
   logic               sign_q, sign_d;
   logic               ovf_q, ovf_d, conv_ovf;
   logic [BCD_W-1:0]   dig_q, dig_d;
   logic               osign_q, osign_d;
   logic               oovf_q, oovf_d;
   logic               conv_last, take;

   for (genvar g = 0; g < DIGITS; g++) begin : g_cell
      bcd_add3_cell u_cell (
         .digit_i (bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .digit_o (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   // The bit leaving the top digit is a 10^DIGITS carry: keep it as sticky overflow.
   assign {bcd_shift, mag_shift} = {bcd_adj, mag_q} << 1;
   assign conv_ovf  = ovf_q | bcd_adj[BCD_W-1];
   assign conv_last = (state_q == ST_CONV) && (cnt_q == CNT_LAST);
   assign take      = (state_q == ST_DONE) && out_ready;

   assign in_ready     = (state_q == ST_IDLE);
   assign out_valid    = (state_q == ST_DONE);
   assign out_digits   = dig_q;
   assign out_sign     = osign_q;
   assign out_overflow = oovf_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mag_d   = mag_q;
      bcd_d   = bcd_q;
      sign_d  = sign_q;
      ovf_d   = ovf_q;
      dig_d   = dig_q;
      osign_d = osign_q;
      oovf_d  = oovf_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               sign_d  = in_signed & in_data[DATA_W-1];
               mag_d   = sign_d ? (~in_data + DATA_W'(1)) : in_data;
               bcd_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = ST_CONV;
            end
         end
         ST_CONV: begin
            bcd_d = bcd_shift;
            mag_d = mag_shift;
            ovf_d = conv_ovf;
            cnt_d = cnt_q + CNT_W'(1);
            if (conv_last) begin
               dig_d   = bcd_shift;
               osign_d = sign_q;
               oovf_d  = conv_ovf;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         mag_q   <= '0;
         bcd_q   <= '0;
         sign_q  <= 1'b0;
         ovf_q   <= 1'b0;
         dig_q   <= '0;
         osign_q <= 1'b0;
         oovf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mag_q   <= mag_d;
         bcd_q   <= bcd_d;
         sign_q  <= sign_d;
         ovf_q   <= ovf_d;
         dig_q   <= dig_d;
         osign_q <= osign_d;
         oovf_q  <= oovf_d;
      end
   end

`ifdef BCD_BLANK_EN
   logic [DIGITS-1:0] blank_q, blank_d, blank_calc;

   // Scan from the top digit down; a digit blanks while everything above it is zero.
   always_comb begin
      logic all_zero;
      int unsigned idx;
      blank_calc = '0;
      all_zero   = 1'b1;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         idx      = DIGITS - 1 - k;
         all_zero = all_zero & (bcd_shift[idx*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
         if (idx != 0) blank_calc[idx] = all_zero;
      end
   end

   always_comb begin
      blank_d = blank_q;
      if (conv_last) blank_d = blank_calc;
      else if (take) blank_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) blank_q <= '0;
      else     blank_q <= blank_d;
   end

   assign out_blank = blank_q;
`else
   assign out_blank = '0;
`endif

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Directed bench for bcd_convert_seq (5-digit and 3-digit instances).
module tb_bcd_convert_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        in_valid = 1'b0, in_signed = 1'b0, out_ready = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_ready, out_valid, out_sign, out_overflow;
   logic [19:0] out_digits;
   logic [4:0]  out_blank;

   logic        in_valid3 = 1'b0, out_ready3 = 1'b0;
   logic [15:0] in_data3 = '0;
   logic        in_ready3, out_valid3, out_sign3, out_overflow3;
   logic [11:0] out_digits3;
   logic [2:0]  out_blank3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bcd_convert_seq #(.DATA_W(16), .DIGITS(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_signed(in_signed),
      .out_valid(out_valid), .out_ready(out_ready), .out_digits(out_digits),
      .out_sign(out_sign), .out_overflow(out_overflow), .out_blank(out_blank)
   );

   bcd_convert_seq #(.DATA_W(16), .DIGITS(3)) dut3 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .in_signed(1'b0),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_digits(out_digits3),
      .out_sign(out_sign3), .out_overflow(out_overflow3), .out_blank(out_blank3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run5(input logic [15:0] d, input logic s, output int lat);
      in_data = d; in_signed = s; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 60) begin
         tick();
         lat++;
      end
   endtask

   task automatic release5();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic run3(input logic [15:0] d, output int lat);
      in_data3 = d; in_valid3 = 1'b1;
      tick();
      in_valid3 = 1'b0;
      lat = 1;
      while (!out_valid3 && lat < 60) begin
         tick();
         lat++;
      end
   endtask

   task automatic release3();
      out_ready3 = 1'b1;
      tick();
      out_ready3 = 1'b0;
   endtask

   initial begin
      int lat;
      logic seen;
      logic [4:0] exp_b42, exp_b0;
`ifdef BCD_BLANK_EN
      exp_b42 = 5'b11100;
      exp_b0  = 5'b11110;
`else
      exp_b42 = 5'b00000;
      exp_b0  = 5'b00000;
`endif

      tick(); tick();
      rst = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_digits", 32'(out_digits), 32'd0);
      check("rst_sign", 32'(out_sign), 32'd0);
      check("rst_ovf", 32'(out_overflow), 32'd0);
      check("rst_blank", 32'(out_blank), 32'd0);

      // unsigned 1234, latency T+17
      run5(16'd1234, 1'b0, lat);
      check("u1234_latency", 32'(lat), 32'd17);
      check("u1234_digits", 32'(out_digits), 32'h01234);
      check("u1234_sign", 32'(out_sign), 32'd0);
      check("u1234_ovf", 32'(out_overflow), 32'd0);
      check("u1234_in_ready", 32'(in_ready), 32'd0);

      // backpressure with a competing input that must be ignored
      in_data = 16'd9999; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_digits", 32'(out_digits), 32'h01234);
      end
      in_valid = 1'b0;
      release5();
      check("rel_valid", 32'(out_valid), 32'd0);
      check("rel_in_ready", 32'(in_ready), 32'd1);

      run5(16'hFB2E, 1'b1, lat);
      check("neg1234_latency", 32'(lat), 32'd17);
      check("neg1234_digits", 32'(out_digits), 32'h01234);
      check("neg1234_sign", 32'(out_sign), 32'd1);
      release5();

      run5(16'h8000, 1'b1, lat);
      check("min_neg_digits", 32'(out_digits), 32'h32768);
      check("min_neg_sign", 32'(out_sign), 32'd1);
      release5();

      run5(16'hFFFF, 1'b0, lat);
      check("uffff_digits", 32'(out_digits), 32'h65535);
      check("uffff_sign", 32'(out_sign), 32'd0);
      check("uffff_ovf", 32'(out_overflow), 32'd0);
      release5();

      run5(16'hFFFF, 1'b1, lat);
      check("neg1_digits", 32'(out_digits), 32'h00001);
      check("neg1_sign", 32'(out_sign), 32'd1);
      release5();

      // abort mid-conversion at T+8
      in_data = 16'd5555; in_signed = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_valid", 32'(out_valid), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      check("abort_no_pulse", 32'(seen), 32'd0);
      run5(16'd4321, 1'b0, lat);
      check("post_abort_latency", 32'(lat), 32'd17);
      check("post_abort_digits", 32'(out_digits), 32'h04321);
      release5();

      run5(16'd42, 1'b0, lat);
      check("d42_digits", 32'(out_digits), 32'h00042);
      check("d42_blank", 32'(out_blank), 32'(exp_b42));
      release5();
      check("blank_cleared", 32'(out_blank), 32'd0);

      run5(16'd0, 1'b1, lat);
      check("zero_digits", 32'(out_digits), 32'h00000);
      check("zero_sign", 32'(out_sign), 32'd0);
      check("zero_blank", 32'(out_blank), 32'(exp_b0));
      release5();

      // 3-digit instance overflow boundary
      run3(16'd1000, lat);
      check("d3_1000_latency", 32'(lat), 32'd17);
      check("d3_1000_ovf", 32'(out_overflow3), 32'd1);
      check("d3_1000_digits", 32'(out_digits3), 32'h000);
      release3();
      run3(16'd999, lat);
      check("d3_999_ovf", 32'(out_overflow3), 32'd0);
      check("d3_999_digits", 32'(out_digits3), 32'h999);
      check("d3_999_sign", 32'(out_sign3), 32'd0);
      release3();
      run3(16'd12345, lat);
      check("d3_12345_ovf", 32'(out_overflow3), 32'd1);
      check("d3_12345_digits", 32'(out_digits3), 32'h345);
      release3();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
